// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited word requests to imem, in-order responses into a
// prefetch FIFO, redirect flush with stale-response drop. Optional: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        instr_misaligned
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   tag_q     [FIFO_DEPTH];
  logic [PW-1:0] tag_rd;
  logic [PW-1:0] tag_wr;

  logic          credit_ok;
  logic          req_fire;
  logic          pop;
  logic          resp_push;
  logic          push;
  logic [31:0]   push_data;
  logic [31:0]   push_pc;
  logic          trap_push;
  logic          halted;
  logic [31:0]   trap_pc;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Credit counts both in-flight requests and buffered words so a response always has a slot.
  assign credit_ok      = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_C;
  assign imem_req_valid = !rst && !redirect_valid && !halted && credit_ok;
  assign imem_req_addr  = pc;
  assign instr_valid    = (fifo_count != '0);
  assign instr          = fifo_data[rd_ptr];
  assign instr_pc       = fifo_pc[rd_ptr];

  always_comb begin
    req_fire  = imem_req_valid && imem_req_ready;
    pop       = instr_valid && instr_ready && !redirect_valid;
    resp_push = imem_resp_valid && (drop == '0) && !redirect_valid;
    push      = resp_push || trap_push;
    push_data = trap_push ? NOP_WORD : imem_resp_data;
    push_pc   = trap_push ? trap_pc : tag_q[tag_rd];
  end

  // Control: fetch PC, in-flight accounting, drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else begin
      if (redirect_valid)
        pc <= align_pc(redirect_pc);
      else if (req_fire)
        pc <= pc + 32'd4;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      // A response landing in the redirect cycle is old-stream, so it is excluded from drop.
      if (redirect_valid)
        drop <= outstanding - CW'(imem_resp_valid);
      else if (imem_resp_valid && (drop != '0))
        drop <= drop - CW'(1);
      if (req_fire)
        tag_wr <= tag_wr + PW'(1);
      if (imem_resp_valid)
        tag_rd <= tag_rd + PW'(1);
    end
  end

  // Issued-address queue; stays aligned with outstanding, so dropped responses pop it too.
  always_ff @(posedge clk) begin
    if (req_fire)
      tag_q[tag_wr] <= pc;
  end

  // Prefetch FIFO; storage clears on reset so instr/instr_pc read zero
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_pc[wr_ptr]   <= push_pc;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_pend;
  logic fifo_mis [FIFO_DEPTH];

  assign trap_push        = trap_pend && (drop == '0) && !redirect_valid;
  assign instr_misaligned = fifo_mis[rd_ptr];

  // Misaligned redirect: stop fetching, emit one NOP marker once old responses drain
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_pend <= 1'b0;
      halted    <= 1'b0;
      trap_pc   <= '0;
    end else if (redirect_valid) begin
      trap_pend <= |redirect_pc[1:0];
      halted    <= |redirect_pc[1:0];
      trap_pc   <= redirect_pc;
    end else if (trap_push) begin
      trap_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo_mis[i] <= 1'b0;
    end else if (push && !redirect_valid) begin
      fifo_mis[wr_ptr] <= trap_push;
    end
  end
`else
  logic unused_pc_lsb;

  assign trap_push     = 1'b0;
  assign halted        = 1'b0;
  assign trap_pc       = '0;
  assign unused_pc_lsb = ^redirect_pc[1:0];
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory with variable latency, epoch-based
// reference model of the fetch stream, redirects, misaligned redirects and mid-run reset.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        instr_misaligned;
`endif

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .instr_misaligned(instr_misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; bit mis; } ent_t;

  mreq_t       memq[$];
  ent_t        mq[$];
  int          epoch, cyc, lat;
  logic [31:0] fetch_pc, trap_pc_m;
  bit          halted_m, trap_pend_m;
  bit          seen_valid;
  logic [31:0] seen_pc, seen_instr;
  int          n_checks, n_errors;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h0031_00B3;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    logic        exp_rv, fire, pop_m, resp, redir, pend_prev;
    logic [31:0] addr, rpc;
    int          sz_prev;
    mreq_t       e;
    @(negedge clk);
    exp_rv = !rst && !redirect_valid && !halted_m && (memq.size() + mq.size() < DEPTH);
    check("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", imem_req_addr, fetch_pc);
    seen_valid = 1'b0;
    if (!rst) begin
      check("instr_valid", instr_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        check("instr", instr, mq[0].data);
        check("instr_pc", instr_pc, mq[0].pc);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("instr_misaligned", instr_misaligned, mq[0].mis);
`endif
      end
      seen_valid = instr_valid;
      seen_pc    = instr_pc;
      seen_instr = instr;
    end
    fire  = imem_req_valid && imem_req_ready && !rst;
    addr  = imem_req_addr;
    pop_m = (mq.size() > 0) && instr_ready && !redirect_valid;
    resp  = imem_resp_valid;
    redir = redirect_valid;
    rpc   = redirect_pc;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      memq.delete();
      mq.delete();
      fetch_pc    = RPC;
      halted_m    = 1'b0;
      trap_pend_m = 1'b0;
    end else begin
      sz_prev   = memq.size();
      pend_prev = trap_pend_m;
      if (redir) begin
        epoch++;
        mq.delete();
        fetch_pc = {rpc[31:2], 2'b00};
        halted_m    = TRAP && (rpc[1:0] != 2'b00);
        trap_pend_m = halted_m;
        trap_pc_m   = rpc;
      end else begin
        if (pop_m) void'(mq.pop_front());
        if (pend_prev && sz_prev == 0) begin
          mq.push_back('{pc: trap_pc_m, data: 32'h0000_0013, mis: 1'b1});
          trap_pend_m = 1'b0;
        end
      end
      if (resp && memq.size() > 0) begin
        e = memq.pop_front();
        if (e.epoch == epoch) mq.push_back('{pc: e.addr, data: memword(e.addr), mis: 1'b0});
      end
      if (fire) begin
        memq.push_back('{addr: addr, epoch: epoch, due: cyc + lat});
        fetch_pc = fetch_pc + 32'd4;
      end
    end
    imem_resp_valid = !rst && (memq.size() > 0) && (memq[0].due <= cyc + 1);
    imem_resp_data  = imem_resp_valid ? memword(memq[0].addr) : 32'hDEAD_BEEF;
  endtask

  task automatic redirect_and_wait(input logic [31:0] pc, input string tag,
                                   input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    bit found;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      found = seen_valid;
    end
    check({tag, "_seen"}, found, 1'b1);
    if (found) begin
      check({tag, "_pc"}, seen_pc, exp_pc);
      check({tag, "_instr"}, seen_instr, exp_instr);
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; epoch = 0; cyc = 0; lat = 1;
    fetch_pc = RPC; trap_pc_m = '0; halted_m = 1'b0; trap_pend_m = 1'b0;
    rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming with 1-cycle memory; first popped word is the ADD at pc 0
    tick();
    tick();
    tick();
    check("first_pc", seen_pc, 32'h0);
    check("first_instr", seen_instr, 32'h0031_00B3);
    repeat (15) tick();

    // Decoder stall: fetch must stop at the credit limit, then resume in order
    instr_ready = 1'b0;
    repeat (10) tick();
    instr_ready = 1'b1;
    repeat (10) tick();

    // Latency 3, redirect with requests in flight
    lat = 3;
    redirect_and_wait(32'h0000_0040, "redir_a", 32'h0000_0040, memword(32'h40));
    repeat (2) tick();
    redirect_and_wait(32'h0000_0100, "redir_100", 32'h0000_0100, memword(32'h100));
    repeat (6) tick();

    // Misaligned redirect: trap marker when enabled, else plain aligned fetch
    redirect_and_wait(32'h0000_0102, "redir_102", TRAP ? 32'h0000_0102 : 32'h0000_0100,
                      TRAP ? 32'h0000_0013 : memword(32'h100));
    instr_ready = 1'b0;
    repeat (8) tick();
    instr_ready = 1'b1;
    repeat (4) tick();

    // PC wrap-around
    lat = 1;
    redirect_and_wait(32'hFFFF_FFF8, "redir_wrap", 32'hFFFF_FFF8, memword(32'hFFFF_FFF8));
    repeat (8) tick();

    // Randomized traffic with redirects and latency changes
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0) lat = $urandom_range(1, 4);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 2) != 0);
      if (!redirect_valid && $urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
        if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
      end else begin
        redirect_valid = 1'b0;
      end
      if (i == 1500) begin
        redirect_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_and_wait(32'h0000_0300, "redir_end", 32'h0000_0300, memword(32'h300));
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
